fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch front end for the RV64I pipeline, sitting between the synchronous instruction RAM and the IF/ID register.
- Replaces ad-hoc stall/flush persistence logic with a decoupling queue of depth DEPTH, a valid/ready handshake to decode, and squashing of in-flight fetches on redirect.
- Adds optional static JAL prediction from pre-decoded fetched words.

---
 rtl/fetch_queue_unit_pkg.sv | 16 +
 rtl/fetch_queue_unit_fifo.sv | 44 ++++
 rtl/fetch_queue_unit.sv | 85 ++++++++
 tb/tb_fetch_queue_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg: shared constants, queue entry layout and JAL immediate extraction
package fetch_queue_unit_pkg;
  localparam int PC_W = 64;
  localparam int INST_W = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
    logic              pred_taken;
  } FetchEntry_t;
  function automatic logic [20:0] jal_imm(input logic [31:0] inst);
    return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo: synchronous show-ahead FIFO of fetch entries with clear taking priority
module fetch_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  FetchEntry_t            data_i,
  output FetchEntry_t            head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  FetchEntry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= do_pop ? rd_q + AW'(1) : rd_q;
      wr_q  <= do_push ? wr_q + AW'(1) : wr_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch front end with decoupling queue, redirect squash and static JAL prediction
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter bit                    PREDICT_JAL = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [INST_WIDTH-1:0] imem_inst_i,
  input  logic                  imem_fault_i,
  input  logic                  redirect_valid_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  if_valid_o,
  input  logic                  if_ready_i,
  output logic [DATA_WIDTH-1:0] if_pc_o,
  output logic [INST_WIDTH-1:0] if_inst_o,
  output logic                  if_fault_o,
  output logic                  if_pred_taken_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, pend_pc_q, pend_pc_d, jal_target;
  logic pending_q, pending_d, pend_drop_q, pend_drop_d, halted_q, halted_d;
  logic [CW-1:0] count, occ;
  logic fifo_full, fifo_empty, issue, accept, jal_hit;
  logic [20:0] imm;
  FetchEntry_t entry, head;
  // in-flight request reserves a slot so the response can never overflow the queue
  assign occ        = count + CW'(pending_q);
  assign issue      = !halted_q && !redirect_valid_i && !fifo_full && occ < CW'(DEPTH);
  assign accept     = pending_q && !pend_drop_q && !redirect_valid_i;
  assign jal_hit    = PREDICT_JAL && accept && !imem_fault_i && imem_inst_i[6:0] == OPC_JAL;
  assign imm        = jal_imm(imem_inst_i);
  assign jal_target = pend_pc_q + {{(DATA_WIDTH-21){imm[20]}}, imm};
  assign entry      = '{pc: pend_pc_q, inst: imem_fault_i ? NOP_INST : imem_inst_i,
                        fault: imem_fault_i, pred_taken: jal_hit};
  assign imem_req_o      = issue && !rst_i;
  assign imem_addr_o     = fetch_pc_q;
  assign if_valid_o      = !fifo_empty;
  assign if_pc_o         = if_valid_o ? head.pc : '0;
  assign if_inst_o       = if_valid_o ? head.inst : '0;
  assign if_fault_o      = if_valid_o && head.fault;
  assign if_pred_taken_o = if_valid_o && head.pred_taken;
  always_comb begin
    fetch_pc_d  = redirect_valid_i ? redirect_pc_i :
                  jal_hit ? jal_target :
                  issue ? fetch_pc_q + DATA_WIDTH'(4) : fetch_pc_q;
    halted_d    = !redirect_valid_i && (halted_q || (accept && imem_fault_i));
    pending_d   = issue;
    pend_pc_d   = issue ? fetch_pc_q : pend_pc_q;
    pend_drop_d = issue ? jal_hit : pend_drop_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q  <= RESET_PC;
      pend_pc_q   <= '0;
      pending_q   <= 1'b0;
      pend_drop_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pend_pc_q   <= pend_pc_d;
      pending_q   <= pending_d;
      pend_drop_q <= pend_drop_d;
      halted_q    <= halted_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (accept),
    .pop_i  (if_valid_o && if_ready_i),
    .clear_i(redirect_valid_i),
    .data_i (entry),
    .head_o (head),
    .count_o(count),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed checks of streaming, backpressure, redirect, JAL prediction and faults
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  logic rst, redirect_valid, ready;
  logic [63:0] redirect_pc;
  logic [31:0] inst_a, inst_b, oi_a, oi_b;
  logic fault_a, fault_b;
  logic req_a, req_b, valid_a, valid_b, flt_a, flt_b, pred_a, pred_b;
  logic [63:0] addr_a, addr_b, pc_a, pc_b;
  bit jal_en = 1'b0, fault_en = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return (jal_en && a == 64'h10) ? 32'h0400006F : {a[11:0], 20'h00013};
  endfunction

  always @(posedge clk) begin
    inst_a  <= word(addr_a);
    fault_a <= fault_en && addr_a == 64'h8;
    inst_b  <= word(addr_b);
    fault_b <= fault_en && addr_b == 64'h8;
  end

  fetch_queue_unit dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req_a), .imem_addr_o(addr_a),
    .imem_inst_i(inst_a), .imem_fault_i(fault_a),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .if_valid_o(valid_a), .if_ready_i(ready), .if_pc_o(pc_a), .if_inst_o(oi_a),
    .if_fault_o(flt_a), .if_pred_taken_o(pred_a)
  );

  fetch_queue_unit #(.PREDICT_JAL(1'b0)) dut_seq (
    .clk_i(clk), .rst_i(rst), .imem_req_o(req_b), .imem_addr_o(addr_b),
    .imem_inst_i(inst_b), .imem_fault_i(fault_b),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .if_valid_o(valid_b), .if_ready_i(ready), .if_pc_o(pc_b), .if_inst_o(oi_b),
    .if_fault_o(flt_b), .if_pred_taken_o(pred_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench one tick into cycle 0, the first cycle out of reset
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    ready = rdy;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", req_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_inst", oi_a, 0);
    chk("rst_fault", flt_a, 0);
    chk("rst_pred", pred_a, 0);

    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) at();
      #1;
      chk("stream_req", req_a, 1);
      chk("stream_addr", addr_a, 64'(4 * k));
      chk("stream_valid", valid_a, k >= 2);
      if (k >= 2) chk("stream_pc", pc_a, 64'(4 * (k - 2)));
      if (k == 4) chk("stream_inst", oi_a, 32'h00800013);
    end

    do_reset(1'b0);
    for (int k = 0; k < 15; k++) begin
      if (k > 0) at();
      if (k == 10) ready = 1'b1;
      #1;
      if (k < 4) chk("bp_req_on", req_a, 1);
      if (k >= 4 && k < 11) chk("bp_req_off", req_a, 0);
      if (k >= 2 && k < 10) chk("bp_head", pc_a, 0);
      if (k >= 10) chk("bp_drain_pc", pc_a, 64'(4 * (k - 10)));
      if (k >= 10) chk("bp_drain_valid", valid_a, 1);
      if (k == 11) chk("bp_resume_addr", addr_a, 64'h10);
    end

    do_reset(1'b0);
    at();
    at();
    at();
    redirect_valid = 1'b1;
    redirect_pc = 64'h200;
    #1;
    chk("rd_req_blocked", req_a, 0);
    at();
    redirect_valid = 1'b0;
    ready = 1'b1;
    #1;
    chk("rd_valid_cleared", valid_a, 0);
    chk("rd_target_addr", addr_a, 64'h200);
    chk("rd_target_req", req_a, 1);
    at();
    #1;
    chk("rd_drop_inflight", valid_a, 0);
    at();
    #1;
    chk("rd_first_valid", valid_a, 1);
    chk("rd_first_pc", pc_a, 64'h200);
    at();
    #1;
    chk("rd_second_pc", pc_a, 64'h204);

    jal_en = 1'b1;
    do_reset(1'b1);
    repeat (5) at();
    #1;
    chk("jal_spec_addr", addr_a, 64'h14);
    at();
    #1;
    chk("jal_target_addr", addr_a, 64'h50);
    chk("jal_head_pc", pc_a, 64'h10);
    chk("jal_head_pred", pred_a, 1);
    chk("jal_head_inst", oi_a, 32'h0400006F);
    chk("seq_head_pc", pc_b, 64'h10);
    chk("seq_head_pred", pred_b, 0);
    chk("seq_addr", addr_b, 64'h18);
    at();
    #1;
    chk("jal_spec_dropped", valid_a, 0);
    chk("seq_pc_14", pc_b, 64'h14);
    at();
    #1;
    chk("jal_next_pc", pc_a, 64'h50);
    chk("jal_next_pred", pred_a, 0);
    chk("seq_pc_18", pc_b, 64'h18);
    chk("seq_pred_18", pred_b, 0);
    jal_en = 1'b0;

    fault_en = 1'b1;
    do_reset(1'b1);
    repeat (4) at();
    #1;
    chk("flt_pc", pc_a, 64'h8);
    chk("flt_flag", flt_a, 1);
    chk("flt_inst", oi_a, 32'h00000013);
    chk("flt_pred", pred_a, 0);
    chk("flt_halt_req", req_a, 0);
    for (int k = 5; k < 8; k++) begin
      at();
      #1;
      chk("flt_no_req", req_a, 0);
      if (k == 5) chk("flt_next_flag", flt_a, 0);
      if (k == 6) chk("flt_drained", valid_a, 0);
    end
    at();
    fault_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h0;
    #1;
    chk("flt_rd_req", req_a, 0);
    at();
    redirect_valid = 1'b0;
    #1;
    chk("flt_resume_req", req_a, 1);
    chk("flt_resume_addr", addr_a, 64'h0);
    at();
    at();
    #1;
    chk("flt_resume_valid", valid_a, 1);
    chk("flt_resume_pc", pc_a, 64'h0);

    jal_en = 1'b1;
    do_reset(1'b1);
    repeat (5) at();
    redirect_valid = 1'b1;
    redirect_pc = 64'h300;
    #1;
    chk("sim_req_blocked", req_a, 0);
    at();
    redirect_valid = 1'b0;
    #1;
    chk("sim_empty", valid_a, 0);
    chk("sim_addr", addr_a, 64'h300);
    chk("sim_req", req_a, 1);
    at();
    #1;
    chk("sim_still_empty", valid_a, 0);
    at();
    #1;
    chk("sim_pc", pc_a, 64'h300);
    chk("sim_pred", pred_a, 0);
    jal_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
